// File: rtl/csr_regfile_if.sv
// CPU-side request/response bundle between the APB4 slave and csr_regfile.
// The slave side issues single-cycle requests; the register file returns registered acks.
interface csr_regfile_if #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
);
   logic                  cpuif_req;
   logic                  cpuif_req_is_wr;
   logic [ADDR_WIDTH-1:0] cpuif_addr;
   logic [DATA_WIDTH-1:0] cpuif_wr_data;
   logic [DATA_WIDTH-1:0] cpuif_wr_biten;
   logic                  cpuif_rd_ack;
   logic                  cpuif_rd_err;
   logic [DATA_WIDTH-1:0] cpuif_rd_data;
   logic                  cpuif_wr_ack;
   logic                  cpuif_wr_err;

   modport master (
      output cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten,
      input  cpuif_rd_ack, cpuif_rd_err, cpuif_rd_data, cpuif_wr_ack, cpuif_wr_err
   );

   modport slave (
      input  cpuif_req, cpuif_req_is_wr, cpuif_addr, cpuif_wr_data, cpuif_wr_biten,
      output cpuif_rd_ack, cpuif_rd_err, cpuif_rd_data, cpuif_wr_ack, cpuif_wr_err
   );
endinterface

// File: rtl/csr_regfile.sv
// Software-visible configuration: ID, scratch, control, W1C interrupt status/mask and a
// compare timer. Every request is answered by a registered ack on the following cycle.
module csr_regfile #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                clk,
   input  logic                rst,
   csr_regfile_if.slave        cpuif,
   input  logic [6:0]          hw_event,
   output logic                ctrl_enable,
   output logic                irq
);
   localparam int IW = ADDR_WIDTH - 2;
   localparam logic [DATA_WIDTH-1:0] ID_VAL  = DATA_WIDTH'(32'hC5A0_0001);
   localparam logic [DATA_WIDTH-1:0] CMP_RST = '1;

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] old_v,
                                                   input logic [DATA_WIDTH-1:0] wd,
                                                   input logic [DATA_WIDTH-1:0] be);
      return (old_v & ~be) | (wd & be);
   endfunction

   logic [IW-1:0] idx;
   logic          hit_id, hit_scr, hit_ctrl, hit_sts, hit_mask, hit_cnt, hit_cmp, mapped;
   logic          wr_req, rd_req, wr_err, rd_err, wr_ok;
   logic [DATA_WIDTH-1:0] wd_be;
   logic          addr_lsb_unused;

   logic [DATA_WIDTH-1:0] scratch_q, scratch_d;
   logic [1:0]            ctrl_q, ctrl_d;
   logic [7:0]            status_q, status_d;
   logic [7:0]            mask_q, mask_d;
   logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] cmp_q, cmp_d;
   logic                  timer_clr, timer_match;

   logic                  rd_ack_q, rd_err_q, wr_ack_q, wr_err_q;
   logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d, rd_val;

   assign idx             = cpuif.cpuif_addr[ADDR_WIDTH-1:2];
   assign addr_lsb_unused = ^cpuif.cpuif_addr[1:0];

   assign hit_id   = (idx == IW'(0));
   assign hit_scr  = (idx == IW'(1));
   assign hit_ctrl = (idx == IW'(2));
   assign hit_sts  = (idx == IW'(3));
   assign hit_mask = (idx == IW'(4));
   assign hit_cnt  = (idx == IW'(5));
   assign hit_cmp  = (idx == IW'(6));
   assign mapped   = hit_id | hit_scr | hit_ctrl | hit_sts | hit_mask | hit_cnt | hit_cmp;

   assign wr_req = cpuif.cpuif_req & cpuif.cpuif_req_is_wr;
   assign rd_req = cpuif.cpuif_req & ~cpuif.cpuif_req_is_wr;
   assign wr_err = wr_req & (hit_id | hit_cnt | ~mapped);
   assign rd_err = rd_req & ~mapped;
   assign wr_ok  = wr_req & ~wr_err;
   assign wd_be  = cpuif.cpuif_wr_data & cpuif.cpuif_wr_biten;

   always_comb begin
      scratch_d   = scratch_q;
      ctrl_d      = ctrl_q;
      status_d    = status_q;
      mask_d      = mask_q;
      cnt_d       = cnt_q;
      cmp_d       = cmp_q;
      timer_clr   = 1'b0;
      timer_match = 1'b0;

      if (wr_ok && hit_scr)
         scratch_d = merge(scratch_q, cpuif.cpuif_wr_data, cpuif.cpuif_wr_biten);
      if (wr_ok && hit_ctrl) begin
         ctrl_d    = (ctrl_q & ~cpuif.cpuif_wr_biten[1:0]) | wd_be[1:0];
         timer_clr = wd_be[2];
      end
      if (wr_ok && hit_mask)
         mask_d = (mask_q & ~cpuif.cpuif_wr_biten[7:0]) | wd_be[7:0];
      if (wr_ok && hit_cmp)
         cmp_d = merge(cmp_q, cpuif.cpuif_wr_data, cpuif.cpuif_wr_biten);

      // Clear wins over both increment and match; the timer runs on the registered enable.
      if (timer_clr) begin
         cnt_d = '0;
      end else if (ctrl_q[1]) begin
         if (cnt_q == cmp_q) begin
            cnt_d       = '0;
            timer_match = 1'b1;
         end else begin
            cnt_d = cnt_q + DATA_WIDTH'(1);
         end
      end

      // Hardware sets are OR'ed in after the W1C so they win on the same bit.
      if (wr_ok && hit_sts)
         status_d = status_q & ~wd_be[7:0];
      status_d = status_d | {timer_match, hw_event};
   end

   always_comb begin
      rd_val = '0;
      if (hit_id)        rd_val = ID_VAL;
      else if (hit_scr)  rd_val = scratch_q;
      else if (hit_ctrl) rd_val = DATA_WIDTH'(ctrl_q);
      else if (hit_sts)  rd_val = DATA_WIDTH'(status_q);
      else if (hit_mask) rd_val = DATA_WIDTH'(mask_q);
      else if (hit_cnt)  rd_val = cnt_q;
      else if (hit_cmp)  rd_val = cmp_q;
      rd_data_d = (rd_req && !rd_err) ? rd_val : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         scratch_q <= '0;
         ctrl_q    <= '0;
         status_q  <= '0;
         mask_q    <= '0;
         cnt_q     <= '0;
         cmp_q     <= CMP_RST;
         rd_ack_q  <= 1'b0;
         rd_err_q  <= 1'b0;
         rd_data_q <= '0;
         wr_ack_q  <= 1'b0;
         wr_err_q  <= 1'b0;
      end else begin
         scratch_q <= scratch_d;
         ctrl_q    <= ctrl_d;
         status_q  <= status_d;
         mask_q    <= mask_d;
         cnt_q     <= cnt_d;
         cmp_q     <= cmp_d;
         rd_ack_q  <= rd_req;
         rd_err_q  <= rd_err;
         rd_data_q <= rd_data_d;
         wr_ack_q  <= wr_req;
         wr_err_q  <= wr_err;
      end
   end

   assign cpuif.cpuif_rd_ack  = rd_ack_q;
   assign cpuif.cpuif_rd_err  = rd_err_q;
   assign cpuif.cpuif_rd_data = rd_data_q;
   assign cpuif.cpuif_wr_ack  = wr_ack_q;
   assign cpuif.cpuif_wr_err  = wr_err_q;

   assign ctrl_enable = ctrl_q[0];
   assign irq         = |(status_q & mask_q);
endmodule
